// File: rtl/run_match_pkg.sv
// Shared types and default constants for the run-length match scheduler.
package run_match_pkg;

    localparam int unsigned NCH_DEF        = 4;
    localparam int unsigned CW_DEF         = 4;
    localparam int unsigned THRESH_RST_DEF = 4;

    // Per-channel match FSM encoding; 2'b11 is unused and recovers to IDLE.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_HIT  = 2'b10;
    localparam state_t ST_ILL  = 2'b11;

endpackage

// File: rtl/run_match_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    input  logic                   en,
    output logic [NCH-1:0]         gnt,
    output logic [$clog2(NCH)-1:0] gnt_idx
);

    localparam int unsigned PW = $clog2(NCH);

    int unsigned idx;
    logic        found;

    // Rotating priority search starting at ptr, wrapping modulo NCH.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (en && !found && req[PW'(idx)]) begin
                found           = 1'b1;
                gnt[PW'(idx)]   = 1'b1;
                gnt_idx         = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/run_match_scheduler.sv
// Round-robin scheduler sharing one run-length comparator across NCH serial channels.
module run_match_scheduler
    import run_match_pkg::*;
#(
    parameter int unsigned NCH        = NCH_DEF,
    parameter int unsigned CW         = CW_DEF,
    parameter int unsigned THRESH_RST = THRESH_RST_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_thresh,
    input  logic [NCH-1:0] ch_valid,
    input  logic [NCH-1:0] ch_x,
    output logic [NCH-1:0] ch_ready,
    output logic [NCH-1:0] match,
    output logic [NCH-1:0] match_valid,
    output logic [CW-1:0]  dp_in1,
    output logic [CW-1:0]  dp_in2,
    input  logic           dp_out,
    output logic           busy
);

    localparam int unsigned PW      = $clog2(NCH);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0] PTR_LAST = PW'(NCH - 1);

    logic [PW-1:0]  ptr_q;
    logic [PW-1:0]  ptr_d;
    logic [CW-1:0]  thresh_q;
    logic [CW-1:0]  count_q [NCH];
    state_t         state_q [NCH];
    logic [CW-1:0]  count_d [NCH];
    state_t         state_d [NCH];

    logic           arb_en;
    logic [NCH-1:0] gnt;
    logic [PW-1:0]  gnt_idx;
    logic           any_gnt;
    logic [CW-1:0]  cur_count;
    logic [CW-1:0]  cand;

    // Reset forces grants off immediately so nothing is consumed while held.
    assign arb_en  = start & ~reset;
    assign any_gnt = |gnt;
    assign busy    = start & ~reset & (|ch_valid);

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .req     (ch_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign ch_ready = gnt;

    // Candidate count for the granted channel, saturating at the counter maximum.
    always_comb begin
        cur_count = count_q[gnt_idx];
        cand      = (cur_count == CNT_MAX) ? cur_count : cur_count + CW'(1);
    end

    // Comparator operands: candidate only during a grant, threshold always.
    always_comb begin
        dp_in1 = any_gnt ? cand : '0;
        dp_in2 = thresh_q;
    end

    // Next arbitration pointer: one past the granted channel.
    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt) begin
            ptr_d = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PW'(1);
        end
    end

    // Pointer and threshold registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            thresh_q <= CW'(THRESH_RST);
        end else begin
            ptr_q <= ptr_d;
            if (cfg_we) begin
                thresh_q <= cfg_thresh;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch

        // Channel FSM: x=1 extends the run and consults the comparator, x=0 or a bad encoding restarts.
        always_comb begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            if (gnt[i]) begin
                if ((state_q[i] == ST_ILL) || !ch_x[i]) begin
                    state_d[i] = ST_IDLE;
                    count_d[i] = '0;
                end else begin
                    count_d[i] = cand;
                    state_d[i] = dp_out ? ST_HIT : ST_RUN;
                end
            end
        end

        // Channel state, count and registered status outputs.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q[i]     <= ST_IDLE;
                count_q[i]     <= '0;
                match[i]       <= 1'b0;
                match_valid[i] <= 1'b0;
            end else begin
                state_q[i]     <= state_d[i];
                count_q[i]     <= count_d[i];
                match[i]       <= (state_d[i] == ST_HIT);
                match_valid[i] <= gnt[i];
            end
        end

    end

endmodule
